// File: rtl/gate_vec_pkg.sv
// gate_vec_pkg: shared types and constants for the gate stimulus sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_vec_pkg;

  // Number of (A,B) input combinations swept per pass
  localparam int NUM_VEC = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Expected/observed gate outputs. Field names avoid the gate-primitive keywords.
  typedef struct packed {
    logic andV;
    logic orV;
    logic notV;
    logic nandV;
    logic nand2V;
  } gate_out_t;

  // Bits needed to count 0..n-1, never less than one
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gate_vec_gen_ref.sv
// gate_ref_model: expected gate outputs for a given (A,B) pair.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module gate_ref_model
  import gate_vec_pkg::*;
(
  input  logic      iA,
  input  logic      iB,
  output gate_out_t oExp
);

  // Truth table of every gate under test
  always_comb begin
    oExp        = '0;
    oExp.andV   = iA & iB;
    oExp.orV    = iA | iB;
    oExp.notV   = ~iA;
    oExp.nandV  = ~(iA & iB);
    oExp.nand2V = ~(iA & iB);
  end

endmodule

// File: rtl/gate_vec_gen.sv
// gate_vec_gen: sweeps (A,B) through 00,01,10,11, HOLD_CYCLES each, REPEAT passes; GATE_VEC_CHECK_EN adds an output checker.
// Latency: first vector driven from the edge that accepts iStart; oDone one cycle after the last driven cycle.
// Backpressure: none; iStart outside IDLE is dropped, not queued.
module gate_vec_gen
  import gate_vec_pkg::*;
#(
  parameter int HOLD_CYCLES = 100,
  parameter int REPEAT      = 1
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic       iAND,
  input  logic       iOR,
  input  logic       iNOT,
  input  logic       iNAND,
  input  logic       iNAND2,
  output logic       oA,
  output logic       oB,
  output logic       oValid,
  output logic       oBusy,
  output logic [1:0] oIdx,
  output logic       oDone,
  output logic       oErr,
  output logic [1:0] oErrIdx
);

  localparam int HOLD_W = cntWidth(HOLD_CYCLES);
  localparam int PASS_W = cntWidth(REPEAT);

  state_t            state;
  state_t            nextState;
  logic [HOLD_W-1:0] holdCnt;
  logic [1:0]        idxCnt;
  logic [PASS_W-1:0] passCnt;
  logic              lastHold;
  logic              lastVec;
  logic              lastPass;

  assign lastHold = (holdCnt == HOLD_W'(HOLD_CYCLES - 1));
  assign lastVec  = (idxCnt == 2'(NUM_VEC - 1));
  assign lastPass = (passCnt == PASS_W'(REPEAT - 1));

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state and status outputs; vector outputs are forced to zero outside DRIVE
  always_comb begin
    nextState = state;
    oValid    = 1'b0;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    oIdx      = 2'd0;
    case (state)
      IDLE: begin
        if (iStart) nextState = DRIVE;
      end
      DRIVE: begin
        oValid = 1'b1;
        oBusy  = 1'b1;
        oIdx   = idxCnt;
        if (lastHold && lastVec && lastPass) nextState = DONE;
      end
      DONE: begin
        oBusy     = 1'b1;
        oDone     = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign oA = oIdx[1];
  assign oB = oIdx[0];

  // Hold/index/pass counters; parked at zero outside DRIVE so a start always begins at vector 0
  always_ff @(posedge iClk) begin
    if (iRst || (state != DRIVE)) begin
      holdCnt <= '0;
      idxCnt  <= '0;
      passCnt <= '0;
    end else if (lastHold) begin
      holdCnt <= '0;
      idxCnt  <= idxCnt + 1'b1;
      if (lastVec && !lastPass) passCnt <= passCnt + 1'b1;
    end else begin
      holdCnt <= holdCnt + 1'b1;
    end
  end

`ifdef GATE_VEC_CHECK_EN
  gate_out_t expOut;
  gate_out_t actOut;
  logic      mismatch;
  logic      errReg;
  logic [1:0] errIdxReg;

  gate_ref_model uRef (
    .iA   (oA),
    .iB   (oB),
    .oExp (expOut)
  );

  assign actOut   = {iAND, iOR, iNOT, iNAND, iNAND2};
  // 4-state compare so X/Z feedback is reported rather than silently accepted
  assign mismatch = (actOut !== expOut);

  // Sticky first-mismatch capture, sampled on the final hold cycle of each vector
  always_ff @(posedge iClk) begin
    if (iRst) begin
      errReg    <= 1'b0;
      errIdxReg <= 2'd0;
    end else if ((state == IDLE) && iStart) begin
      errReg    <= 1'b0;
      errIdxReg <= 2'd0;
    end else if ((state == DRIVE) && lastHold && mismatch && !errReg) begin
      errReg    <= 1'b1;
      errIdxReg <= idxCnt;
    end
  end

  assign oErr    = errReg;
  assign oErrIdx = errIdxReg;
`else
  // Checker absent: feedback inputs are deliberately ignored
  logic unusedChk;
  assign unusedChk = ^{iAND, iOR, iNOT, iNAND, iNAND2};
  assign oErr      = 1'b0;
  assign oErrIdx   = 2'd0;
`endif

endmodule

// File: tb/tb_gate_vec_gen.sv
// tb_gate_vec_gen: directed bench for gate_vec_gen with a cycle-offset reference model.
// Two instances: REPEAT=1 and REPEAT=2, both HOLD_CYCLES=4, sharing clock/reset/start.
// Gate feedback is modelled in the bench, with an override that pins NAND2 high.
module tb_gate_vec_gen;

  localparam int H = 4;
`ifdef GATE_VEC_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic forceN2 = 1'b0;

  logic o1A, o1B, o1Valid, o1Busy, o1Done, o1Err;
  logic [1:0] o1Idx, o1ErrIdx;
  logic o2A, o2B, o2Valid, o2Busy, o2Done, o2Err;
  logic [1:0] o2Idx, o2ErrIdx;

  int nCmp = 0;
  int nBad = 0;

  initial forever #5 clk = ~clk;

  gate_vec_gen #(.HOLD_CYCLES(H), .REPEAT(1)) u1 (
    .iClk(clk), .iRst(rst), .iStart(start),
    .iAND(o1A & o1B), .iOR(o1A | o1B), .iNOT(~o1A), .iNAND(~(o1A & o1B)),
    .iNAND2(forceN2 ? 1'b1 : ~(o1A & o1B)),
    .oA(o1A), .oB(o1B), .oValid(o1Valid), .oBusy(o1Busy), .oIdx(o1Idx),
    .oDone(o1Done), .oErr(o1Err), .oErrIdx(o1ErrIdx)
  );

  gate_vec_gen #(.HOLD_CYCLES(H), .REPEAT(2)) u2 (
    .iClk(clk), .iRst(rst), .iStart(start),
    .iAND(o2A & o2B), .iOR(o2A | o2B), .iNOT(~o2A), .iNAND(~(o2A & o2B)),
    .iNAND2(forceN2 ? 1'b1 : ~(o2A & o2B)),
    .oA(o2A), .oB(o2B), .oValid(o2Valid), .oBusy(o2Busy), .oIdx(o2Idx),
    .oDone(o2Done), .oErr(o2Err), .oErrIdx(o2ErrIdx)
  );

  task automatic chk(input string name, input int act, input int exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance is either idle (off=-1) or at cycle offset off since its start.
  // Offsets 0..len-1 drive vector (off/H)%4; offset len is the done cycle.
  int off[2] = '{-1, -1};
  int lenV[2] = '{4 * H * 1, 4 * H * 2};
  bit errM[2] = '{1'b0, 1'b0};
  int errIdxM[2] = '{0, 0};

  function automatic logic [9:0] expVec(input int o, input int len, input bit e, input int ei);
    int ix;
    bit v;
    v  = (o >= 0) && (o < len);
    ix = v ? (o / H) % 4 : 0;
    return {v, (o >= 0), (o == len), ix[1], ix[0], ix[1:0], e, ei[1:0]};
  endfunction

  // Advance the model on each rising edge, then compare both instances just after it
  always begin
    bit rS, sS, fS;
    @(posedge clk);
    rS = rst; sS = start; fS = forceN2;
    for (int d = 0; d < 2; d++) begin
      if (rS) begin
        off[d] = -1; errM[d] = 1'b0; errIdxM[d] = 0;
      end else if (off[d] < 0) begin
        if (sS) begin
          off[d] = 0; errM[d] = 1'b0; errIdxM[d] = 0;
        end
      end else begin
        // NAND2 pinned high only disagrees where A=B=1, i.e. vector 3
        if (EXP_ERR && off[d] < lenV[d] && (off[d] % H) == H - 1 &&
            ((off[d] / H) % 4) == 3 && fS && !errM[d]) begin
          errM[d] = 1'b1; errIdxM[d] = 3;
        end
        off[d]++;
        if (off[d] > lenV[d]) off[d] = -1;
      end
    end
    #1;
    chk("u1_outputs", int'({o1Valid, o1Busy, o1Done, o1A, o1B, o1Idx, o1Err, o1ErrIdx}),
        int'(expVec(off[0], lenV[0], errM[0], errIdxM[0])));
    chk("u2_outputs", int'({o2Valid, o2Busy, o2Done, o2A, o2B, o2Idx, o2Err, o2ErrIdx}),
        int'(expVec(off[1], lenV[1], errM[1], errIdxM[1])));
  end

  initial begin
    int doneCnt;
    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_busy", o1Busy, 0);
      chk("rst_valid", o1Valid, 0);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_valid", o1Valid, 0);
      chk("idle_done", o2Done, 0);
    end

    // Normal sweep with a second start during DRIVE that must be ignored
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 0)  begin chk("k0_valid", o1Valid, 1); chk("k0_ab", {o1A, o1B}, 0); chk("k0_busy", o1Busy, 1); end
      if (i == 4)  begin chk("k4_ab", {o1A, o1B}, 1); chk("k4_idx", o1Idx, 1); end
      if (i == 8)  chk("k8_ab", {o1A, o1B}, 2);
      if (i == 12) chk("k12_ab", {o1A, o1B}, 3);
      if (i == 15) begin chk("k15_valid", o1Valid, 1); chk("k15_idx", o1Idx, 3); end
      if (i == 16) begin
        chk("k16_done", o1Done, 1); chk("k16_valid", o1Valid, 0); chk("k16_busy", o1Busy, 1);
        chk("r2_k16_idx", o2Idx, 0); chk("r2_k16_valid", o2Valid, 1); chk("r2_k16_done", o2Done, 0);
      end
      if (i == 17) begin chk("k17_busy", o1Busy, 0); chk("k17_done", o1Done, 0); end
      if (i == 31) chk("r2_k31_idx", o2Idx, 3);
      if (i == 32) chk("r2_k32_done", o2Done, 1);
      if (i == 33) chk("r2_k33_busy", o2Busy, 0);
      @(negedge clk); start = (i == 4);
    end

    // NAND2 pinned high: mismatch only on vector 3
    @(negedge clk); forceN2 = 1'b1; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 15) chk("err_before", o1Err, 0);
      if (i == 16) begin
        chk("err_u1", o1Err, EXP_ERR); chk("erridx_u1", o1ErrIdx, EXP_ERR ? 3 : 0);
        chk("err_u2", o2Err, EXP_ERR); chk("erridx_u2", o2ErrIdx, EXP_ERR ? 3 : 0);
      end
      if (i == 39) chk("err_sticky", o2Err, EXP_ERR);
      @(negedge clk); start = 1'b0;
    end
    forceN2 = 1'b0; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin chk("err_clr_u1", o1Err, 0); chk("err_clr_u2", o2Err, 0); end
      if (i == 39) chk("err_clean_run", o2Err, 0);
      @(negedge clk); start = 1'b0;
    end

    // Reset at k+6 aborts without a done pulse
    start = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 6) begin
        chk("abort_valid", o1Valid, 0); chk("abort_busy", o1Busy, 0);
        chk("abort_idx", o1Idx, 0); chk("abort_u2_busy", o2Busy, 0);
      end
      if (i >= 6 && o1Done) doneCnt++;
      @(negedge clk); start = 1'b0; rst = (i == 5);
    end
    chk("abort_no_done", doneCnt, 0);
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 0)  chk("restart_valid", o1Valid, 1);
      if (i == 16) chk("restart_done", o1Done, 1);
      if (i == 32) chk("restart_r2_done", o2Done, 1);
      @(negedge clk); start = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
